// File: rtl/dsram_axi_bridge_if.sv
// AXI3 master-side bus bundle between the data SRAM bridge and the interconnect.
interface dsram_axi_bridge_if #(
    parameter int unsigned ID_W = 4
) ();
    logic [ID_W-1:0] arid;
    logic [31:0]     araddr;
    logic [3:0]      arlen;
    logic [2:0]      arsize;
    logic [1:0]      arburst;
    logic            arvalid;
    logic            arready;

    logic [ID_W-1:0] rid;
    logic [31:0]     rdata;
    logic [1:0]      rresp;
    logic            rlast;
    logic            rvalid;
    logic            rready;

    logic [ID_W-1:0] awid;
    logic [31:0]     awaddr;
    logic [3:0]      awlen;
    logic [2:0]      awsize;
    logic [1:0]      awburst;
    logic            awvalid;
    logic            awready;

    logic [ID_W-1:0] wid;
    logic [31:0]     wdata;
    logic [3:0]      wstrb;
    logic            wlast;
    logic            wvalid;
    logic            wready;

    logic [ID_W-1:0] bid;
    logic [1:0]      bresp;
    logic            bvalid;
    logic            bready;

    modport master (
        output arid, araddr, arlen, arsize, arburst, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready,
        output awid, awaddr, awlen, awsize, awburst, awvalid,
        input  awready,
        output wid, wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready
    );

    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready,
        input  awid, awaddr, awlen, awsize, awburst, awvalid,
        output awready,
        input  wid, wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready
    );
endinterface

// File: rtl/dsram_axi_bridge.sv
// Single-outstanding bridge from the core's data SRAM port to an AXI3 master port.
// The core is stalled while a transaction is in flight; read data returns in DONE.
module dsram_axi_bridge #(
    parameter int unsigned ID_W   = 4,
    parameter int unsigned AXI_ID = 1
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 data_sram_en,
    input  logic [3:0]           data_sram_wen,
    input  logic [31:0]          data_sram_addr,
    input  logic [31:0]          data_sram_wdata,
    output logic [31:0]          data_sram_rdata,
    output logic                 stall_by_dram,
    output logic                 bus_err,
    dsram_axi_bridge_if.master   axi
);
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned SW = 4;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_AR   = 3'd1,
        RD_R    = 3'd2,
        WR_AW_W = 3'd3,
        WR_B    = 3'd4,
        DONE    = 3'd5
    } state_e;

    state_e          state_q, state_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [SW-1:0]   wen_q, wen_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic [2:0]      awsize_q, awsize_d;
    logic [1:0]      resp_q, resp_d;
    logic [DW-1:0]   rdata_q, rdata_d;
    logic            aw_done_q, aw_done_d;
    logic            w_done_q, w_done_d;
    logic            arvalid_q, arvalid_d;
    logic            rready_q, rready_d;
    logic            awvalid_q, awvalid_d;
    logic            wvalid_q, wvalid_d;
    logic            bready_q, bready_d;
    logic            bus_err_q, bus_err_d;
    logic            unused_ok;

    // Transfer size from the byte-enable pattern; odd patterns fall back to a full word.
    function automatic logic [2:0] size_of(input logic [SW-1:0] be);
        case (be)
            4'b1111:                            size_of = 3'b010;
            4'b0011, 4'b1100:                   size_of = 3'b001;
            4'b0001, 4'b0010, 4'b0100, 4'b1000: size_of = 3'b000;
            default:                            size_of = 3'b010;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            wen_q     <= '0;
            wdata_q   <= '0;
            awsize_q  <= '0;
            resp_q    <= '0;
            rdata_q   <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wen_q     <= wen_d;
            wdata_q   <= wdata_d;
            awsize_q  <= awsize_d;
            resp_q    <= resp_d;
            rdata_q   <= rdata_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            arvalid_q <= arvalid_d;
            rready_q  <= rready_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            bready_q  <= bready_d;
            bus_err_q <= bus_err_d;
        end
    end

    // Next state and datapath; bus outputs are registered from the next state.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wen_d     = wen_q;
        wdata_d   = wdata_q;
        awsize_d  = awsize_q;
        resp_d    = resp_q;
        rdata_d   = rdata_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;

        case (state_q)
            IDLE: begin
                if (data_sram_en) begin
                    addr_d    = data_sram_addr;
                    wen_d     = data_sram_wen;
                    wdata_d   = data_sram_wdata;
                    awsize_d  = size_of(data_sram_wen);
                    resp_d    = 2'b00;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = (data_sram_wen == 4'b0000) ? RD_AR : WR_AW_W;
                end
            end
            RD_AR: begin
                if (arvalid_q && axi.arready) state_d = RD_R;
            end
            RD_R: begin
                if (rready_q && axi.rvalid) begin
                    rdata_d = axi.rdata;
                    resp_d  = axi.rresp;
                    state_d = DONE;
                end
            end
            WR_AW_W: begin
                aw_done_d = aw_done_q | (awvalid_q & axi.awready);
                w_done_d  = w_done_q  | (wvalid_q  & axi.wready);
                if (aw_done_d && w_done_d) state_d = WR_B;
            end
            WR_B: begin
                if (bready_q && axi.bvalid) begin
                    resp_d  = axi.bresp;
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        arvalid_d = (state_d == RD_AR);
        rready_d  = (state_d == RD_R);
        awvalid_d = (state_d == WR_AW_W) && !aw_done_d;
        wvalid_d  = (state_d == WR_AW_W) && !w_done_d;
        bready_d  = (state_d == WR_B);
        bus_err_d = (state_d == DONE) && (resp_d != 2'b00);
    end

    // A new request is stalled in the very cycle it shows up.
    assign stall_by_dram = ((state_q == IDLE) && data_sram_en) ||
                           ((state_q != IDLE) && (state_q != DONE));

    assign data_sram_rdata = rdata_q;
    assign bus_err         = bus_err_q;

    assign axi.arid    = ID_W'(AXI_ID);
    assign axi.araddr  = addr_q;
    assign axi.arlen   = 4'b0000;
    assign axi.arsize  = 3'b010;
    assign axi.arburst = 2'b01;
    assign axi.arvalid = arvalid_q;
    assign axi.rready  = rready_q;

    assign axi.awid    = ID_W'(AXI_ID);
    assign axi.awaddr  = addr_q;
    assign axi.awlen   = 4'b0000;
    assign axi.awsize  = awsize_q;
    assign axi.awburst = 2'b01;
    assign axi.awvalid = awvalid_q;

    assign axi.wid     = ID_W'(AXI_ID);
    assign axi.wdata   = wdata_q;
    assign axi.wstrb   = wen_q;
    assign axi.wlast   = 1'b1;
    assign axi.wvalid  = wvalid_q;
    assign axi.bready  = bready_q;

    // Single outstanding, single-beat: IDs and rlast carry no information here.
    assign unused_ok = &{1'b0, axi.rid, axi.rlast, axi.bid};
endmodule

// File: tb/tb_dsram_axi_bridge.sv
// Self-checking bench: table of transactions against a configurable AXI slave model,
// with a scoreboard of expected DONE results plus reset and idle sequences.
module tb_dsram_axi_bridge;
    logic        clk = 1'b0;
    logic        resetn;
    logic        en;
    logic [3:0]  wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata_o;
    logic        stall;
    logic        err;

    int total = 0;
    int bad   = 0;

    dsram_axi_bridge_if #(.ID_W(4)) axi ();

    dsram_axi_bridge #(.ID_W(4), .AXI_ID(1)) dut (
        .clk             (clk),
        .resetn          (resetn),
        .data_sram_en    (en),
        .data_sram_wen   (wen),
        .data_sram_addr  (addr),
        .data_sram_wdata (wdata),
        .data_sram_rdata (rdata_o),
        .stall_by_dram   (stall),
        .bus_err         (err),
        .axi             (axi)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_wr;
        logic [31:0] addr;
        logic [3:0]  wen;
        logic [31:0] wdata;
        logic [31:0] rdata_in;
        logic [1:0]  resp;
        int          ar_dly;
        int          r_dly;
        int          aw_dly;
        int          w_dly;
        int          b_dly;
        bit          hold_en;
        logic [2:0]  exp_size;
        bit          exp_err;
        int          exp_lat;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        bit          err;
        int          lat;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] model_rdata;
    vec_t        vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic slave_idle();
        axi.arready = 1'b0;
        axi.rvalid  = 1'b0;
        axi.rdata   = 32'h0;
        axi.rresp   = 2'b00;
        axi.rid     = 4'd1;
        axi.rlast   = 1'b1;
        axi.awready = 1'b0;
        axi.wready  = 1'b0;
        axi.bvalid  = 1'b0;
        axi.bresp   = 2'b00;
        axi.bid     = 4'd1;
    endtask

    task automatic run_txn(input vec_t v);
        int ar_cyc = 0, aw_cyc = 0, w_cyc = 0;
        int ar_hs = 0, aw_hs = 0, w_hs = 0;
        int r_t = 0, b_t = 0, viol = 0;
        bit r_arm = 0, b_arm = 0, b_started = 0, done = 0;
        logic [2:0] obs_size = 3'bxxx;
        exp_t e, got;

        @(negedge clk);
        slave_idle();
        en    = 1'b1;
        addr  = v.addr;
        wen   = v.wen;
        wdata = v.wdata;
        e.rdata = v.is_wr ? model_rdata : v.rdata_in;
        e.err   = v.exp_err;
        e.lat   = v.exp_lat;
        sb.push_back(e);
        if (!v.is_wr) model_rdata = v.rdata_in;
        #1;
        chk("req_stall", 32'(stall), 32'd1);
        chk("idle_err", 32'(err), 32'd0);

        for (int k = 1; k <= 60 && !done; k++) begin
            @(negedge clk);
            slave_idle();
            if (!stall) begin
                done = 1;
                got  = sb.pop_front();
                chk("latency", 32'(k), 32'(got.lat));
                chk("rdata", rdata_o, got.rdata);
                chk("bus_err", 32'(err), 32'(got.err));
                if (!v.hold_en) en = 1'b0;
            end else begin
                if (err) viol++;
                if (r_arm) begin
                    r_t++;
                    if (r_t >= v.r_dly) begin
                        if (!axi.rready) viol++;
                        axi.rvalid = 1'b1;
                        axi.rdata  = v.rdata_in;
                        axi.rresp  = v.resp;
                        r_arm      = 0;
                    end
                end
                if (axi.arvalid) begin
                    if (ar_hs > 0) viol++;
                    if (ar_cyc == 0) obs_size = axi.arsize;
                    if (axi.araddr !== v.addr || axi.arsize !== obs_size || axi.arlen !== 4'd0 ||
                        axi.arburst !== 2'b01 || axi.arid !== 4'd1) viol++;
                    ar_cyc++;
                    if (ar_cyc == v.ar_dly + 1) begin
                        axi.arready = 1'b1;
                        ar_hs++;
                        r_arm = 1;
                        r_t   = 0;
                    end
                end
                if (b_arm) begin
                    b_t++;
                    if (b_t >= v.b_dly) begin
                        if (!axi.bready) viol++;
                        axi.bvalid = 1'b1;
                        axi.bresp  = v.resp;
                        b_arm      = 0;
                    end
                end
                if (axi.awvalid) begin
                    if (aw_hs > 0) viol++;
                    if (aw_cyc == 0) obs_size = axi.awsize;
                    if (axi.awaddr !== v.addr || axi.awsize !== obs_size || axi.awlen !== 4'd0 ||
                        axi.awburst !== 2'b01 || axi.awid !== 4'd1) viol++;
                    aw_cyc++;
                    if (aw_cyc == v.aw_dly + 1) begin
                        axi.awready = 1'b1;
                        aw_hs++;
                    end
                end
                if (axi.wvalid) begin
                    if (w_hs > 0) viol++;
                    if (axi.wdata !== v.wdata || axi.wstrb !== v.wen || axi.wlast !== 1'b1 ||
                        axi.wid !== 4'd1) viol++;
                    w_cyc++;
                    if (w_cyc == v.w_dly + 1) begin
                        axi.wready = 1'b1;
                        w_hs++;
                    end
                end
                if (!b_started && aw_hs > 0 && w_hs > 0) begin
                    b_started = 1;
                    b_arm     = 1;
                    b_t       = 0;
                end
            end
        end

        if (!done) begin
            total++;
            bad++;
            $display("FAIL timeout: no DONE for addr %h within 60 cycles", v.addr);
            if (sb.size() > 0) void'(sb.pop_front());
        end
        if (v.is_wr) begin
            chk("aw_count", 32'(aw_hs), 32'd1);
            chk("w_count", 32'(w_hs), 32'd1);
            chk("ar_none", 32'(ar_hs), 32'd0);
            chk("awvalid_cycles", 32'(aw_cyc), 32'(v.aw_dly + 1));
        end else begin
            chk("ar_count", 32'(ar_hs), 32'd1);
            chk("aw_w_none", 32'(aw_hs + w_hs), 32'd0);
            chk("arvalid_cycles", 32'(ar_cyc), 32'(v.ar_dly + 1));
        end
        chk("size", 32'(obs_size), 32'(v.exp_size));
        chk("protocol", 32'(viol), 32'd0);
    endtask

    initial begin
        // is_wr addr wen wdata rdata_in resp ar r aw w b hold size err lat
        vecs[0] = '{0, 32'h8000_0010, 4'b0000, 32'h0, 32'hDEAD_BEEF, 2'b00, 3, 2, 0, 0, 1, 0, 3'b010, 0, 7};
        vecs[1] = '{1, 32'h0000_0042, 4'b0100, 32'h00AB_0000, 32'h0, 2'b00, 0, 1, 2, 0, 1, 0, 3'b000, 0, 5};
        vecs[2] = '{1, 32'h0000_0100, 4'b1111, 32'h1234_5678, 32'h0, 2'b10, 0, 1, 0, 0, 1, 0, 3'b010, 1, 3};
        vecs[3] = '{0, 32'h0000_0200, 4'b0000, 32'h0, 32'hCAFE_F00D, 2'b00, 0, 1, 0, 0, 1, 1, 3'b010, 0, 3};
        vecs[4] = '{1, 32'h0000_0204, 4'b0011, 32'h0000_BEEF, 32'h0, 2'b00, 0, 1, 0, 1, 2, 0, 3'b001, 0, 5};
        vecs[5] = '{1, 32'h0000_0206, 4'b1100, 32'h5A5A_0000, 32'h0, 2'b00, 0, 1, 0, 0, 1, 0, 3'b001, 0, 3};
        vecs[6] = '{0, 32'h0000_0300, 4'b0000, 32'h0, 32'h1357_9BDF, 2'b11, 0, 1, 0, 0, 1, 0, 3'b010, 1, 3};
        vecs[7] = '{1, 32'h0000_0400, 4'b0101, 32'hA5A5_A5A5, 32'h0, 2'b01, 0, 1, 1, 1, 1, 0, 3'b010, 1, 4};

        resetn = 1'b0;
        en     = 1'b0;
        wen    = 4'b0;
        addr   = 32'h0;
        wdata  = 32'h0;
        slave_idle();
        model_rdata = 32'h0;
        repeat (2) @(negedge clk);
        chk("rst_arvalid", 32'(axi.arvalid), 32'd0);
        chk("rst_awvalid", 32'(axi.awvalid), 32'd0);
        chk("rst_wvalid", 32'(axi.wvalid), 32'd0);
        chk("rst_rready", 32'(axi.rready), 32'd0);
        chk("rst_bready", 32'(axi.bready), 32'd0);
        chk("rst_rdata", rdata_o, 32'h0);
        chk("rst_bus_err", 32'(err), 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        resetn = 1'b1;

        for (int i = 0; i < 8; i++) run_txn(vecs[i]);

        // Reset while waiting in RD_R abandons the read and clears read data.
        @(negedge clk);
        slave_idle();
        en   = 1'b1;
        addr = 32'h0000_0500;
        wen  = 4'b0000;
        @(negedge clk);
        chk("rst_seq_arvalid", 32'(axi.arvalid), 32'd1);
        axi.arready = 1'b1;
        @(negedge clk);
        axi.arready = 1'b0;
        chk("rst_seq_rready", 32'(axi.rready), 32'd1);
        en     = 1'b0;
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        chk("rst_seq_rready_low", 32'(axi.rready), 32'd0);
        chk("rst_seq_stall", 32'(stall), 32'd0);
        chk("rst_seq_rdata", rdata_o, 32'h0);
        chk("rst_seq_arvalid_low", 32'(axi.arvalid), 32'd0);
        model_rdata = 32'h0;

        run_txn(vecs[5]);

        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("idle_quiet", 32'({axi.arvalid, axi.awvalid, axi.wvalid, stall, err}), 32'd0);
        end
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/dsram_axi_bridge.md
Name: dsram_axi_bridge

Overview:
- Converts the core's single-cycle data SRAM port (en/wen/addr/wdata/rdata) into an AXI3 master port.
- At most one outstanding transaction at a time.
- Sits directly downstream of the mips core's data_sram_* port, between the core and the AXI interconnect.
- Asserts a stall back to the core while a transaction is in flight, and returns read data on the cycle the stall drops.

Parameters:
- ID_W, 4, width of all AXI ID fields.
- AXI_ID, 1, constant ID driven on arid/awid/wid.

Ports:
- clk  in  1  clock; all logic on rising edge
- resetn  in  1  synchronous reset, active low
- data_sram_en  in  1  core request valid
- data_sram_wen  in  4  byte write enables; 0000 = read
- data_sram_addr  in  32  byte address
- data_sram_wdata  in  32  write data
- data_sram_rdata  out  32  read data, valid in DONE cycle
- stall_by_dram  out  1  core must hold request and pipeline while high
- bus_err  out  1  one-cycle pulse in DONE if rresp/bresp != 00
- arid  out  ID_W; araddr  out  32; arlen  out  4 (=0); arsize  out  3; arburst  out  2 (=01); arvalid  out  1; arready  in  1
- rid  in  ID_W; rdata  in  32; rresp  in  2; rlast  in  1; rvalid  in  1; rready  out  1
- awid  out  ID_W; awaddr  out  32; awlen  out  4 (=0); awsize  out  3; awburst  out  2 (=01); awvalid  out  1; awready  in  1
- wid  out  ID_W; wdata  out  32; wstrb  out  4; wlast  out  1 (=1); wvalid  out  1; wready  in  1
- bid  in  ID_W; bresp  in  2; bvalid  in  1; bready  out  1

Behaviour:
- Reset (resetn low at a clock edge) → state IDLE.
  - All valid/ready outputs 0; data_sram_rdata = 0; bus_err = 0.
  - All latched request registers cleared.
  - Reset overrides any in-flight handshake. The bridge does not wait for the slave; the interconnect is reset with it.
- States: IDLE, RD_AR, RD_R, WR_AW_W, WR_B, DONE.
- IDLE:
  - If data_sram_en is high, latch addr/wen/wdata.
  - wen == 0000 → next state RD_AR. Otherwise → WR_AW_W.
- RD_AR:
  - arvalid = 1; araddr = latched addr; arsize = 010.
  - On arvalid & arready → RD_R.
- RD_R:
  - rready = 1.
  - On rvalid → latch rdata into data_sram_rdata, latch rresp; → DONE.
  - rid and rlast are ignored.
- WR_AW_W:
  - awvalid and wvalid are both raised on entry. Each is dropped independently after its own handshake, using internal flags aw_done and w_done.
  - Handshakes may complete in either order or in the same cycle.
  - When both flags are set (including the cycle the last one completes) → WR_B.
  - wstrb = latched wen; wdata = latched wdata; awaddr = latched addr.
  - awsize from wen: 1111 → 010; 0011 or 1100 → 001; any single bit → 000; any other pattern → 010.
- WR_B:
  - bready = 1.
  - On bvalid → latch bresp; → DONE.
- DONE (exactly one cycle):
  - stall_by_dram = 0. data_sram_rdata holds the read data (unchanged after a write).
  - bus_err = 1 if the latched resp != 00.
  - The request visible on data_sram_en this cycle is the already-served one and is ignored.
  - → IDLE unconditionally.
- stall_by_dram (combinational) = (state == IDLE & data_sram_en) | (state ∉ {IDLE, DONE}).
  - A new request is therefore stalled in the same cycle it appears.
- Latency:
  - Read with arready and rvalid both immediate: request at cycle 0, AR handshake at cycle 1, R at cycle 2, DONE at cycle 3.
  - Write with all ready immediate: AW/W at cycle 1, B at cycle 2, DONE at cycle 3.
- Request-stability rule:
  - The core holds en/addr/wen/wdata stable while stalled. The bridge uses only the values latched in IDLE.
  - Changes to inputs mid-transaction are ignored.
- Valid-stability rule: once raised, arvalid, awvalid and wvalid stay high, with payload unchanged, until their handshake completes.
- data_sram_rdata is updated only on an R handshake.
- Back-to-back: the earliest a new request is accepted is the IDLE cycle after DONE.

Test Plan:
- Read, arready delayed 3 cycles, rvalid 2 cycles after AR, rdata = 32'hDEADBEEF, addr 32'h8000_0010.
  → araddr = 32'h8000_0010, arsize = 010, arvalid held 4 cycles.
  → stall high until DONE; DONE shows rdata = DEADBEEF, stall 0, bus_err 0.
- Byte write, wen = 0100, addr 32'h0000_0042, wdata 32'h00AB0000, wready before awready (gap 2 cycles).
  → wvalid drops after the W handshake while awvalid stays high; awsize = 000, wstrb = 0100.
  → DONE after bvalid.
- Word write with awready and wready in the same cycle, bresp = 10.
  → WR_B entered the next cycle; bus_err pulses for exactly 1 cycle in DONE.
- Back-to-back read then write with en held continuously.
  → exactly one AR and one AW; the second transaction starts in the IDLE cycle after DONE; no duplicate transaction from the DONE cycle.
- resetn low for one cycle while in RD_R.
  → next cycle: state IDLE, rready 0, stall 0 (with en low), data_sram_rdata 0.
- Halfword write, wen = 1100, all ready immediate.
  → awsize = 001; DONE exactly 3 cycles after the request; rdata unchanged from the previous read.
